// File: rtl/mmio_pkg.sv
// ============================================================
// mmio_pkg: shared constants for the memory-mapped IO bridge
// Rev 1.0
// ============================================================
`default_nettype none

package mmio_pkg;

  localparam logic [21:0] c_IO_BASE_HI = 22'h3FFFFF;

  localparam int c_CH_SWITCH = 0;
  localparam int c_CH_LED    = 1;
  localparam int c_CH_SEG    = 2;
  localparam int c_CH_KEY    = 3;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;
  localparam logic [1:0] c_ST_ERR  = 2'd3;

  // A single channel still needs a 1-bit index field.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_addr_decode.sv
// ============================================================
// mmio_addr_decode: IO window hit, channel and word offset
// Rev 1.0
// ============================================================
`default_nettype none

module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter logic [21:0] BASE_HI  = c_IO_BASE_HI,
  parameter int          NUM_CH   = 4,
  parameter int          CH_SHIFT = 4,
  localparam int         CH_W     = ch_width(NUM_CH)
) (
  input  logic [31:0]         cpu_addr,
  output logic                hit,
  output logic [CH_W-1:0]     ch,
  output logic [CH_SHIFT-3:0] offset
);

  logic [9:0] w_upper;
  logic       w_unused_addr;

  assign ch     = cpu_addr[CH_SHIFT +: CH_W];
  assign offset = cpu_addr[CH_SHIFT-1:2];

  // Address bits above the channel field must be zero for a hit.
  assign w_upper = cpu_addr[9:0] >> (CH_SHIFT + CH_W);

  assign hit = (cpu_addr[31:10] == BASE_HI) &&
               (w_upper == 10'd0) &&
               ({1'b0, ch} < (CH_W+1)'(NUM_CH));

  assign w_unused_addr = &{1'b0, cpu_addr[1:0]};

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// ============================================================
// mmio_bridge: CPU data-port to NUM_CH IO device bridge
// Rev 1.0
// ============================================================
`default_nettype none

module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          IO_W     = 16,
  parameter int          NUM_CH   = 4,
  parameter logic [21:0] BASE_HI  = c_IO_BASE_HI,
  parameter int          CH_SHIFT = 4,
  parameter int          TIMEOUT  = 255,
  parameter int          SIGN_EXT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic                   cpu_err,
  output logic [NUM_CH-1:0]      io_valid,
  output logic                   io_we,
  output logic [CH_SHIFT-3:0]    io_offset,
  output logic [IO_W-1:0]        io_wdata,
  input  logic [NUM_CH*IO_W-1:0] io_rdata,
  input  logic [NUM_CH-1:0]      io_ack
);

  localparam int               c_CH_W     = ch_width(NUM_CH);
  localparam int               c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [1:0]          r_state;
  logic [c_CH_W-1:0]   r_ch;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                w_hit;
  logic [c_CH_W-1:0]   w_ch;
  logic [CH_SHIFT-3:0] w_offset;
  logic                w_sel_ack;
  logic [IO_W-1:0]     w_sel_data;
  logic [DATA_W-1:0]   w_rd_ext;
  logic [IO_W-1:0]     w_slices [NUM_CH];
  logic                w_unused_wdata;

  mmio_addr_decode #(
    .BASE_HI  (BASE_HI),
    .NUM_CH   (NUM_CH),
    .CH_SHIFT (CH_SHIFT)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .hit      (w_hit),
    .ch       (w_ch),
    .offset   (w_offset)
  );

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_slices[k] = io_rdata[k*IO_W +: IO_W];
      assign io_valid[k] = (r_state == c_ST_REQ) && (r_ch == c_CH_W'(k));
    end
  endgenerate

  // Acks and data from channels other than the latched one are ignored.
  always_comb begin
    w_sel_ack  = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == c_CH_W'(k)) begin
        w_sel_ack  = io_ack[k];
        w_sel_data = w_slices[k];
      end
    end
  end

  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign w_rd_ext = DATA_W'($signed(w_sel_data));
    end else begin : g_zext
      assign w_rd_ext = DATA_W'(w_sel_data);
    end
  endgenerate

  // Stall is forced low while reset is held so the CPU is released at once.
  assign cpu_stall = !reset && (((r_state == c_ST_IDLE) && cpu_req) ||
                                (r_state == c_ST_REQ));
  assign cpu_err   = (r_state == c_ST_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_ch      <= '0;
      r_cnt     <= '0;
      cpu_rdata <= '0;
      io_we     <= 1'b0;
      io_offset <= '0;
      io_wdata  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (cpu_req) begin
            r_ch      <= w_ch;
            io_offset <= w_offset;
            io_we     <= cpu_we;
            io_wdata  <= cpu_wdata[IO_W-1:0];
            r_cnt     <= '0;
            if (w_hit) begin
              r_state <= c_ST_REQ;
            end else begin
              r_state   <= c_ST_ERR;
              cpu_rdata <= '0;
            end
          end
        end
        c_ST_REQ: begin
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_sel_ack) begin
            cpu_rdata <= io_we ? '0 : w_rd_ext;
            r_state   <= c_ST_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            cpu_rdata <= '0;
            r_state   <= c_ST_ERR;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        c_ST_ERR:  r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign w_unused_wdata = &{1'b0, cpu_wdata};

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// ============================================================
// tb_mmio_bridge: directed bench for mmio_bridge, zero- and sign-extending
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mmio_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [63:0] io_rdata;
  logic [3:0]  io_ack;

  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, err0, err1, we0, we1;
  logic [3:0]  valid0, valid1;
  logic [1:0]  off0, off1;
  logic [15:0] wdata0, wdata1;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    int          ack_ch;
    logic [3:0]  stray;
    int          exp_nreq;
    logic        exp_err;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [3:0]  exp_valid;
    logic [1:0]  exp_off;
  } vec_t;

  vec_t vecs [8];

  mmio_bridge #(.DATA_W(32), .IO_W(16), .NUM_CH(4), .CH_SHIFT(4),
                .TIMEOUT(8), .SIGN_EXT(0)) dut0 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0),
    .cpu_stall(stall0), .cpu_err(err0), .io_valid(valid0), .io_we(we0),
    .io_offset(off0), .io_wdata(wdata0), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  mmio_bridge #(.DATA_W(32), .IO_W(16), .NUM_CH(4), .CH_SHIFT(4),
                .TIMEOUT(8), .SIGN_EXT(1)) dut1 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1),
    .cpu_stall(stall1), .cpu_err(err1), .io_valid(valid1), .io_we(we1),
    .io_offset(off1), .io_wdata(wdata1), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nreq;
    bit done;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; io_ack = '0;
    @(negedge clk);
    check($sformatf("v%0d_idle_stall", idx), 32'(stall0), 32'd1);
    check($sformatf("v%0d_idle_valid", idx), 32'(valid0), 32'd0);
    nreq = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (valid0 != 4'd0) begin
        check($sformatf("v%0d_req_valid", idx), 32'(valid0), 32'(v.exp_valid));
        check($sformatf("v%0d_req_offset", idx), 32'(off0), 32'(v.exp_off));
        check($sformatf("v%0d_req_we", idx), 32'(we0), 32'(v.we));
        check($sformatf("v%0d_req_wdata", idx), 32'(wdata0), 32'(v.wdata[15:0]));
        check($sformatf("v%0d_req_stall", idx), 32'(stall0), 32'd1);
        io_ack = v.stray;
        if (v.ack_at == nreq) io_ack[v.ack_ch] = 1'b1;
        nreq++;
      end else begin
        io_ack = '0;
        check($sformatf("v%0d_nreq", idx), 32'(nreq), 32'(v.exp_nreq));
        check($sformatf("v%0d_end_stall", idx), 32'(stall0), 32'd0);
        check($sformatf("v%0d_err0", idx), 32'(err0), 32'(v.exp_err));
        check($sformatf("v%0d_err1", idx), 32'(err1), 32'(v.exp_err));
        check($sformatf("v%0d_rdata0", idx), rdata0, v.exp_rd0);
        check($sformatf("v%0d_rdata1", idx), rdata1, v.exp_rd1);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL v%0d_bound: transaction did not finish within 40 cycles", idx);
    end
    // cpu_req is still high across the DONE/ERR edge; it must not start a new access.
    @(posedge clk); #1;
    cpu_req = 1'b0;
    io_ack  = '0;
    @(negedge clk);
    check($sformatf("v%0d_post_err", idx), 32'(err0), 32'd0);
    check($sformatf("v%0d_post_valid", idx), 32'(valid0), 32'd0);
    check($sformatf("v%0d_post_stall", idx), 32'(stall0), 32'd0);
    check($sformatf("v%0d_rdata_hold", idx), rdata0, v.exp_rd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Device read data: ch3=0x7FFF, ch2=0x1234, ch1=0x5555, ch0=0x8001
    io_rdata  = {16'h7FFF, 16'h1234, 16'h5555, 16'h8001};
    io_ack    = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    reset     = 1'b1;

    //            we    addr          wdata         ack_at ch stray  nreq err   rd0           rd1           valid off
    vecs[0] = '{1'b0, 32'hFFFFFC00, 32'h00000000, 0,   0, 4'h0, 1, 1'b0, 32'h00008001, 32'hFFFF8001, 4'h1, 2'd0};
    vecs[1] = '{1'b0, 32'h00001000, 32'h00000000, 255, 0, 4'h0, 0, 1'b1, 32'h00000000, 32'h00000000, 4'h0, 2'd0};
    vecs[2] = '{1'b1, 32'hFFFFFC14, 32'hDEADBEEF, 5,   1, 4'h0, 6, 1'b0, 32'h00000000, 32'h00000000, 4'h2, 2'd1};
    vecs[3] = '{1'b0, 32'hFFFFFC2C, 32'h00000000, 7,   2, 4'h0, 8, 1'b0, 32'h00001234, 32'h00001234, 4'h4, 2'd3};
    vecs[4] = '{1'b0, 32'hFFFFFC40, 32'h00000000, 255, 0, 4'h0, 0, 1'b1, 32'h00000000, 32'h00000000, 4'h0, 2'd0};
    vecs[5] = '{1'b0, 32'hFFFFFC30, 32'h00000000, 0,   3, 4'h0, 1, 1'b0, 32'h00007FFF, 32'h00007FFF, 4'h8, 2'd0};
    vecs[6] = '{1'b0, 32'hFFFFFC38, 32'h00000000, 255, 3, 4'h0, 8, 1'b1, 32'h00000000, 32'h00000000, 4'h8, 2'd2};
    vecs[7] = '{1'b0, 32'hFFFFFC00, 32'h00000000, 2,   0, 4'h4, 3, 1'b0, 32'h00008001, 32'hFFFF8001, 4'h1, 2'd0};

    #12;
    check("rst_rdata", rdata0, 32'h0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_offset", 32'(off0), 32'd0);
    check("rst_wdata", 32'(wdata0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a request that never gets an ack
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFFFC00; io_ack = '0;
    @(posedge clk); #1;
    check("midrst_pre_valid", 32'(valid0), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(valid0), 32'd0);
    check("midrst_stall", 32'(stall0), 32'd0);
    check("midrst_err", 32'(err0), 32'd0);
    check("midrst_rdata", rdata0, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised memory-mapped IO bridge between the single-cycle CPU data port and NUM_CH IO devices (switches, LEDs, 7-seg, keypad).
- Generalises the fixed 16-bit switch/LED path:
  - arbitrary channel count and IO width;
  - per-transaction valid/ack handshake with CPU stall;
  - timeout and decode-error reporting.
- Sits beside data memory; the CPU routes loads/stores whose address high bits match the IO window here.

Parameters:
- DATA_W, 32: CPU data width.
- IO_W, 16: device data width; must be less than or equal to DATA_W.
- NUM_CH, 4: number of IO channels, 1..16.
- BASE_HI, 22'h3FFFFF: required value of cpu_addr[31:10] (IO window 0xFFFFFC00).
- CH_SHIFT, 4: channel index starts at cpu_addr[CH_SHIFT]; each channel owns 2^CH_SHIFT bytes.
- TIMEOUT, 255: cycles waited for io_ack before error.
- SIGN_EXT, 0: 1 means read data is sign-extended from IO_W to DATA_W; 0 means zero-extended.

Ports:
- clk, in, 1: single clock, divided CPU clock.
- reset, in, 1: asynchronous, active-high.
- cpu_req, in, 1: IO access this instruction (IORead or IOWrite).
- cpu_we, in, 1: 1 means write, 0 means read.
- cpu_addr, in, 32: byte address (ALU result).
- cpu_wdata, in, DATA_W: store data.
- cpu_rdata, out, DATA_W: load data; valid when cpu_stall=0 in DONE.
- cpu_stall, out, 1: freezes PC/regfile write while high.
- cpu_err, out, 1: one-cycle pulse, decode miss or timeout.
- io_valid, out, NUM_CH: one-hot request strobe.
- io_we, out, 1: write qualifier.
- io_offset, out, CH_SHIFT-2: word offset within channel.
- io_wdata, out, IO_W: write data.
- io_rdata, in, NUM_CH*IO_W: per-channel read data, channel k at [k*IO_W +: IO_W].
- io_ack, in, NUM_CH: per-channel completion.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state=IDLE;
  - cpu_rdata, cpu_stall, cpu_err, io_valid, io_we, io_offset, io_wdata, timeout counter all 0.
- State machine: IDLE, REQ, DONE, ERR.
- IDLE:
  - cpu_stall = cpu_req (combinational).
  - On cpu_req, latch ch = cpu_addr[CH_SHIFT +: clog2(NUM_CH)], offset, cpu_we and cpu_wdata[IO_W-1:0].
  - Decode hit (cpu_addr[31:10]==BASE_HI and ch<NUM_CH, with unused upper channel bits zero) goes to REQ; otherwise goes to ERR.
- REQ:
  - io_valid[ch]=1 and cpu_stall=1; io_we, io_offset and io_wdata are held stable.
  - Counter increments each cycle.
  - If io_ack[ch]=1: capture the io_rdata slice, extended per SIGN_EXT (writes capture 0), and go to DONE.
  - Else if counter==TIMEOUT-1: go to ERR.
  - Ack and timeout in the same cycle: ack wins.
  - io_ack on non-selected channels is ignored.
- DONE: io_valid=0, cpu_stall=0, cpu_rdata=captured value; cpu_req is ignored (same instruction retiring); next state IDLE.
- ERR: io_valid=0, cpu_stall=0, cpu_err=1, cpu_rdata=0; next state IDLE; no device is ever strobed.
- Latency: acked transaction minimum 3 cycles (IDLE, REQ, DONE), stall high 2 cycles; each extra wait cycle adds one.
- cpu_rdata holds its last value outside DONE/ERR.
- Counter is cleared on entry to REQ.
- Counter width is clog2(TIMEOUT+1).

Decomposition:
- Package mmio_pkg:
  - state enum (IDLE/REQ/DONE/ERR);
  - default IO base constant 22'h3FFFFF;
  - channel assignments CH_SWITCH=0, CH_LED=1, CH_SEG=2, CH_KEY=3.
- Sub-module mmio_addr_decode (combinational): cpu_addr in, hit/ch/offset out, reused by data memory gating.

Test Plan:
- Read, SIGN_EXT=0: read 0xFFFFFC00, device 0 acks in the first REQ cycle with 0x8001 → stall high 2 cycles, DONE cpu_rdata=0x00008001, err=0.
- Read, SIGN_EXT=1: same read → cpu_rdata=0xFFFF8001.
- Write with wait states: write 0xDEADBEEF to 0xFFFFFC14 (ch1, offset1), ack after 5 cycles → io_valid=0b0010 for 6 cycles, io_wdata=0xBEEF, io_offset=1, stall released in DONE.
- Decode misses: request to 0x00001000, then 0xFFFFFC40 with NUM_CH=4 → ERR next cycle, cpu_err pulse, io_valid never set.
- Timeout, TIMEOUT=8, no ack → REQ for exactly 8 cycles, then ERR pulse; ack on the 8th cycle instead → DONE, no error.
- Robustness: stray io_ack[2] during a ch0 transaction is ignored; reset asserted mid-REQ → io_valid and stall drop immediately, and the next request after reset completes normally.
